// File: rtl/mem_arb_pkg.sv
// +-----------------------------------------------------------------------------+
// | Module      : mem_arb_pkg                                                   |
// | Description : Shared encodings for the two-port RAM arbiter.               |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    localparam logic CPU_PORT = 1'b0;
    localparam logic AUX_PORT = 1'b1;

    // 2'b11 is illegal and treated like MNONE: never granted.
    function automatic logic cmd_active(input logic [1:0] cmd);
        return (cmd == MREAD) || (cmd == MWRITE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
// +-----------------------------------------------------------------------------+
// | Module      : arb_pick                                                      |
// | Description : Combinational two-way picker; round-robin on a tie, or fixed  |
// |               CPU priority when ARB_CPU_PRIORITY_EN is defined.             |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module arb_pick
    import mem_arb_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_gnt,
    output logic winner
);

`ifdef ARB_CPU_PRIORITY_EN
    logic w_unused_last_gnt;
    assign w_unused_last_gnt = last_gnt;

    always_comb begin
        winner = CPU_PORT;
        if (!valid0 && valid1) begin
            winner = AUX_PORT;
        end
    end
`else
    always_comb begin
        winner = CPU_PORT;
        if (valid0 && valid1) begin
            // The port that did not win last time takes the tie.
            winner = (last_gnt == CPU_PORT) ? AUX_PORT : CPU_PORT;
        end else if (valid1) begin
            winner = AUX_PORT;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +-----------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                   |
// | Description : Two-port arbiter serialising CPU and aux-master one-word      |
// |               transactions onto a single synchronous RAM. Tie-break policy  |
// |               is selected by ARB_CPU_PRIORITY_EN (see arb_pick).            |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          req0,
    input  logic [1:0]    cmd0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,

    input  logic          req1,
    input  logic [1:0]    cmd1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,

    output logic [1:0]    mem_cmd,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t r_state;
    logic   r_last_gnt;
    logic   r_winner;

    logic   w_valid0;
    logic   w_valid1;
    logic   w_winner;

    assign w_valid0 = req0 && cmd_active(cmd0);
    assign w_valid1 = req1 && cmd_active(cmd1);

    arb_pick u_pick (
        .valid0   (w_valid0),
        .valid1   (w_valid1),
        .last_gnt (r_last_gnt),
        .winner   (w_winner)
    );

    // The mem_* registers double as the transaction latch, so ISSUE drives
    // the RAM straight from flops and IDLE/RDWAIT simply hold the address.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_last_gnt <= AUX_PORT;
            r_winner   <= CPU_PORT;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            mem_cmd    <= MNONE;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;

            case (r_state)
                IDLE: begin
                    mem_cmd <= MNONE;
                    if (w_valid0 || w_valid1) begin
                        r_state    <= ISSUE;
                        r_winner   <= w_winner;
                        r_last_gnt <= w_winner;
                        gnt0       <= (w_winner == CPU_PORT);
                        gnt1       <= (w_winner == AUX_PORT);
                        if (w_winner == CPU_PORT) begin
                            mem_cmd   <= cmd0;
                            mem_addr  <= addr0;
                            mem_wdata <= wdata0;
                        end else begin
                            mem_cmd   <= cmd1;
                            mem_addr  <= addr1;
                            mem_wdata <= wdata1;
                        end
                    end
                end

                ISSUE: begin
                    mem_cmd <= MNONE;
                    r_state <= (mem_cmd == MREAD) ? RDWAIT : IDLE;
                end

                RDWAIT: begin
                    r_state <= IDLE;
                    if (r_winner == CPU_PORT) begin
                        rdata0  <= mem_rdata;
                        rvalid0 <= 1'b1;
                    end else begin
                        rdata1  <= mem_rdata;
                        rvalid1 <= 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    mem_cmd <= MNONE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +-----------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                                |
// | Description : Directed scoreboard bench for mem_arbiter with a RAM model;   |
// |               tie expectations follow ARB_CPU_PRIORITY_EN.                  |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1;
    logic [1:0]    cmd0, cmd1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    logic [DW-1:0] ram [0:(1<<AW)-1];

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .cmd0      (cmd0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .rvalid0   (rvalid0),
        .rdata0    (rdata0),
        .req1      (req1),
        .cmd1      (cmd1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt1      (gnt1),
        .rvalid1   (rvalid1),
        .rdata1    (rdata1),
        .mem_cmd   (mem_cmd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous RAM: read data is valid the cycle after MREAD.
    always @(posedge clk) begin
        if (mem_cmd == MWRITE) ram[mem_addr] <= mem_wdata;
        if (mem_cmd == MREAD)  mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response side of the scoreboard plus one-hot invariants.
    always @(negedge clk) begin
        if (reset) begin
            check("gnt_onehot", {31'd0, gnt0 && gnt1}, 32'd0);
            check("rvalid_onehot", {31'd0, rvalid0 && rvalid1}, 32'd0);
            if (rvalid0) begin
                if (q0.size() == 0) check("rvalid0_unexpected", 32'd1, 32'd0);
                else check("rdata0", {16'd0, rdata0}, {16'd0, q0.pop_front()});
            end
            if (rvalid1) begin
                if (q1.size() == 0) check("rvalid1_unexpected", 32'd1, 32'd0);
                else check("rdata1", {16'd0, rdata1}, {16'd0, q1.pop_front()});
            end
        end
    end

    task automatic aux_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1 = 1'b1; cmd1 = MWRITE; addr1 = a; wdata1 = d;
        tick();
        check("aux_wr_gnt1", {31'd0, gnt1}, 32'd1);
        check("aux_wr_gnt0", {31'd0, gnt0}, 32'd0);
        check("aux_wr_cmd", {30'd0, mem_cmd}, {30'd0, MWRITE});
        check("aux_wr_addr", {23'd0, mem_addr}, {23'd0, a});
        check("aux_wr_data", {16'd0, mem_wdata}, {16'd0, d});
        req1 = 1'b0; cmd1 = MNONE;
        tick();
        check("aux_wr_done", {30'd0, mem_cmd}, {30'd0, MNONE});
    endtask

    initial begin
        logic exp_port;

        reset = 1'b0;
        req0 = 1'b0; cmd0 = MNONE; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; cmd1 = MNONE; addr1 = '0; wdata1 = '0;

        // Reset then idle
        tick(); tick();
        check("rst_cmd", {30'd0, mem_cmd}, {30'd0, MNONE});
        check("rst_addr", {23'd0, mem_addr}, 32'd0);
        check("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        check("rst_rdata0", {16'd0, rdata0}, 32'd0);
        check("rst_rdata1", {16'd0, rdata1}, 32'd0);
        reset = 1'b1;
        tick(); tick();
        check("idle_cmd", {30'd0, mem_cmd}, {30'd0, MNONE});
        check("idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check("idle_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);

        // Preload via port 1; leaves last grant on port 1
        aux_write(9'h001, 16'h1111);
        aux_write(9'h002, 16'h2222);

        // Simultaneous held reads: grant every 3 cycles
        req0 = 1'b1; cmd0 = MREAD; addr0 = 9'h001;
        req1 = 1'b1; cmd1 = MREAD; addr1 = 9'h002;
        for (int k = 0; k < 3; k++) begin
`ifdef ARB_CPU_PRIORITY_EN
            exp_port = CPU_PORT;
`else
            exp_port = (k % 2 == 1) ? AUX_PORT : CPU_PORT;
`endif
            tick();
            check("tie_gnt0", {31'd0, gnt0}, {31'd0, exp_port == CPU_PORT});
            check("tie_gnt1", {31'd0, gnt1}, {31'd0, exp_port == AUX_PORT});
            check("tie_cmd", {30'd0, mem_cmd}, {30'd0, MREAD});
            check("tie_addr", {23'd0, mem_addr}, (exp_port == AUX_PORT) ? 32'h2 : 32'h1);
            if (exp_port == CPU_PORT) q0.push_back(16'h1111);
            else q1.push_back(16'h2222);
            if (k == 2) begin
                req0 = 1'b0; cmd0 = MNONE;
                req1 = 1'b0; cmd1 = MNONE;
            end
            tick(); tick();
        end
        tick();

        // Port 0 write then read
        req0 = 1'b1; cmd0 = MWRITE; addr0 = 9'h010; wdata0 = 16'hABCD;
        tick();
        check("p0_wr_gnt0", {31'd0, gnt0}, 32'd1);
        check("p0_wr_cmd", {30'd0, mem_cmd}, {30'd0, MWRITE});
        check("p0_wr_addr", {23'd0, mem_addr}, 32'h010);
        check("p0_wr_data", {16'd0, mem_wdata}, 32'hABCD);
        req0 = 1'b0; cmd0 = MNONE;
        tick();
        check("p0_wr_gnt_drop", {31'd0, gnt0}, 32'd0);
        req0 = 1'b1; cmd0 = MREAD; addr0 = 9'h010;
        q0.push_back(16'hABCD);
        tick();
        check("p0_rd_gnt0", {31'd0, gnt0}, 32'd1);
        check("p0_rd_cmd", {30'd0, mem_cmd}, {30'd0, MREAD});
        req0 = 1'b0; cmd0 = MNONE;
        tick();
        check("p0_rd_early", {31'd0, rvalid0}, 32'd0);
        check("p0_rd_wait_cmd", {30'd0, mem_cmd}, {30'd0, MNONE});
        check("p0_rd_wait_addr", {23'd0, mem_addr}, 32'h010);
        tick();
        check("p0_rd_rvalid0", {31'd0, rvalid0}, 32'd1);
        check("p0_rd_rvalid1", {31'd0, rvalid1}, 32'd0);
        tick();
        check("p0_rd_rvalid_drop", {31'd0, rvalid0}, 32'd0);

        // Ignored commands on port 1
        req1 = 1'b1; cmd1 = MNONE; addr1 = 9'h055;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) cmd1 = 2'b11;
            tick();
            check("ign_gnt1", {31'd0, gnt1}, 32'd0);
            check("ign_cmd", {30'd0, mem_cmd}, {30'd0, MNONE});
        end
        req1 = 1'b0; cmd1 = MNONE;
        tick();

        // Back-to-back: port 1 write then port 0 read of the same word
        req1 = 1'b1; cmd1 = MWRITE; addr1 = 9'h020; wdata1 = 16'h1234;
        tick();
        check("b2b_gnt1", {31'd0, gnt1}, 32'd1);
        check("b2b_wr_cmd", {30'd0, mem_cmd}, {30'd0, MWRITE});
        req1 = 1'b0; cmd1 = MNONE;
        req0 = 1'b1; cmd0 = MREAD; addr0 = 9'h020;
        q0.push_back(16'h1234);
        tick();
        check("b2b_gap_gnt0", {31'd0, gnt0}, 32'd0);
        check("b2b_gap_cmd", {30'd0, mem_cmd}, {30'd0, MNONE});
        tick();
        check("b2b_gnt0", {31'd0, gnt0}, 32'd1);
        check("b2b_rd_cmd", {30'd0, mem_cmd}, {30'd0, MREAD});
        req0 = 1'b0; cmd0 = MNONE;
        tick();
        check("b2b_rd_early", {31'd0, rvalid0}, 32'd0);
        tick();
        check("b2b_rvalid0", {31'd0, rvalid0}, 32'd1);
        tick();

        // Reset during RDWAIT aborts the read
        req0 = 1'b1; cmd0 = MREAD; addr0 = 9'h001;
        tick();
        check("abort_gnt0", {31'd0, gnt0}, 32'd1);
        req0 = 1'b0; cmd0 = MNONE;
        tick();
        reset = 1'b0;
        tick();
        check("abort_rvalid0", {31'd0, rvalid0}, 32'd0);
        check("abort_rdata0", {16'd0, rdata0}, 32'd0);
        check("abort_cmd", {30'd0, mem_cmd}, {30'd0, MNONE});
        reset = 1'b1;
        tick();
        check("abort_post_rvalid0", {31'd0, rvalid0}, 32'd0);

        // After reset the first tie goes to port 0, and the FSM is idle
        req0 = 1'b1; cmd0 = MWRITE; addr0 = 9'h040; wdata0 = 16'h4040;
        req1 = 1'b1; cmd1 = MWRITE; addr1 = 9'h030; wdata1 = 16'h3030;
        tick();
        check("post_rst_gnt0", {31'd0, gnt0}, 32'd1);
        check("post_rst_gnt1", {31'd0, gnt1}, 32'd0);
        check("post_rst_addr", {23'd0, mem_addr}, 32'h040);
        req0 = 1'b0; cmd0 = MNONE;
        tick();
        tick();
        check("post_rst_gnt1_late", {31'd0, gnt1}, 32'd1);
        check("post_rst_addr1", {23'd0, mem_addr}, 32'h030);
        req1 = 1'b0; cmd1 = MNONE;
        tick(); tick();

        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter that shares the single synchronous RAM between the CPU (port 0: instruction fetch and load/store) and a second bus master (port 1: program loader or debug/DMA).
- Each port issues one-word transactions through a req/gnt handshake.
- The arbiter serialises them onto the RAM command bus and returns read data to the winning port with a fixed latency.
- Sits between the CPU and the RAM, replacing the direct CPU-to-RAM connection.

Parameters:
AW, 9, address width in bits.
DW, 16, data word width in bits.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-low reset.
req0  input  1  port 0 request.
cmd0  input  2  port 0 command (MNONE/MREAD/MWRITE).
addr0  input  AW  port 0 address.
wdata0  input  DW  port 0 write data.
gnt0  output  1  port 0 grant; one-cycle pulse.
rvalid0  output  1  port 0 read data valid; one-cycle pulse.
rdata0  output  DW  port 0 read data; holds until the next port 0 read.
req1, cmd1, addr1, wdata1, gnt1, rvalid1, rdata1  same as port 0, for port 1.
mem_cmd  output  2  RAM command.
mem_addr  output  AW  RAM address.
mem_wdata  output  DW  RAM write data.
mem_rdata  input  DW  RAM read data, valid one cycle after an MREAD is issued.

Behaviour:
- Command encoding: MNONE=2'b00, MREAD=2'b01, MWRITE=2'b10. 2'b11 is illegal.
- A port is requesting only when req=1 AND its cmd is MREAD or MWRITE. req with MNONE or 2'b11 is ignored and never granted.
- States: IDLE, ISSUE, RDWAIT.
- IDLE:
  - mem_cmd=MNONE; mem_addr and mem_wdata hold their last values.
  - If any port is requesting, pick a winner and latch its cmd/addr/wdata and the winner id. Next state is ISSUE.
  - Otherwise remain in IDLE.
- Arbitration:
  - Single requester: it wins.
  - Both requesting: round-robin. The port not granted last wins.
  - last_gnt updates on every grant.
- ISSUE (exactly one cycle):
  - Drive mem_cmd, mem_addr and mem_wdata from the latched values.
  - gnt of the winner is 1 this cycle only.
  - Requester may change or drop req/cmd/addr/wdata from the cycle after gnt.
  - MWRITE: next state IDLE; the transaction is complete.
  - MREAD: next state RDWAIT.
- RDWAIT:
  - mem_cmd=MNONE; mem_addr held.
  - mem_rdata is registered into the winner's rdata.
  - Next state IDLE.
- rvalid: the winner's rvalid=1 in the cycle after RDWAIT. This coincides with IDLE, which may arbitrate a new request in the same cycle.
- Latency, request sampled in cycle N:
  - gnt in N+1.
  - Write reaches the RAM in N+1.
  - rvalid/rdata in N+3.
  - Earliest next arbitration: N+2 after a write, N+3 after a read.
- Requesters must hold req/cmd/addr/wdata stable from assertion until gnt. Behaviour is undefined otherwise.
- gnt0 and gnt1 are never both 1. rvalid0 and rvalid1 are never both 1.
- Reset values (reset=0 at a clock edge):
  - state=IDLE; last_gnt=1, so port 0 wins the first tie.
  - gnt0, gnt1, rvalid0, rvalid1 = 0.
  - mem_cmd=MNONE; mem_addr=0; mem_wdata=0.
  - rdata0=rdata1=0.
- Reset during ISSUE or RDWAIT aborts the transaction: no rvalid is produced, and a pending write issued that cycle is not guaranteed.
- Reset has priority over all other events.

Optional Feature:
Macro ARB_CPU_PRIORITY_EN.
- Defined: fixed priority. Port 0 always wins a tie; last_gnt is not used.
- Undefined: round-robin as described above.
- All latencies and the handshake are identical in both builds.

Decomposition:
- Package mem_arb_pkg holds:
  - mem_cmd encodings MNONE/MREAD/MWRITE;
  - state encodings IDLE/ISSUE/RDWAIT (2 bits);
  - port id constants CPU_PORT=0 and AUX_PORT=1.
- Sub-module arb_pick: combinational two-way picker. Inputs: valid0, valid1, last_gnt. Output: winner id. The ARB_CPU_PRIORITY_EN variant lives here.
- The FSM, latches and response routing stay in mem_arbiter.

Test Plan:
1. Reset then idle: hold reset=0 for 2 cycles, then reset=1 with no requests → mem_cmd=MNONE, all gnt/rvalid=0, rdata0=rdata1=0.
2. Port 0 write then read: req0, MWRITE, addr0=9'h010, wdata0=16'hABCD → gnt0 and mem_cmd=MWRITE/addr 0x010 one cycle later. Then MREAD of 0x010 → rvalid0 three cycles after request, rdata0=16'hABCD, rvalid1 stays 0.
3. Simultaneous reads: req0 and req1 both MREAD (0x001, 0x002) held continuously → grants alternate port0, port1, port0 (round-robin). Repeat with ARB_CPU_PRIORITY_EN defined → port 0 granted every time while it requests.
4. Ignored commands: req1=1 with cmd1=MNONE, then cmd1=2'b11, for 5 cycles → no gnt1, mem_cmd stays MNONE.
5. Back-to-back: port 1 MWRITE immediately followed by port 0 MREAD → gnt1 at N+1, gnt0 at N+3, rvalid0 at N+5; mem_cmd never MREAD and MWRITE in the same cycle.
6. Reset mid-read: port 0 MREAD, reset=0 during RDWAIT → no rvalid0; state IDLE; rdata0=0 after reset.
